// File: rtl/bus_host_arbiter_pkg.sv
// Shared helpers for the bus host arbiter slice.
// wrap_inc: increment an index and wrap it to zero at the modulus n.
package bus_host_arbiter_pkg;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/bus_host_arbiter_id_fifo.sv
// In-order FIFO of host IDs for granted-but-unanswered transactions.
// Ports: clk_i/rst_i (sync active-high), push_i/push_id_i write side,
// pop_i read side, head_id_o oldest entry, full_o/empty_o status,
// count_o registered occupancy. A push while full or a pop while empty is ignored.
module bus_host_arbiter_id_fifo
    import bus_host_arbiter_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter int unsigned IdWidth = 1,
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW   = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [IdWidth-1:0] push_id_i,
    input  logic               pop_i,
    output logic [IdWidth-1:0] head_id_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CntW-1:0]    count_o
);

    logic [IdWidth-1:0] mem_q [Depth];
    logic [IdWidth-1:0] mem_d [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               do_push, do_pop;

    assign full_o    = (count_q == CntW'(Depth));
    assign empty_o   = (count_q == CntW'(0));
    assign count_o   = count_q;
    assign head_id_o = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = PtrW'(wrap_inc(32'(wr_ptr_q), Depth));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), Depth));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= {IdWidth{1'b0}};
            end
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            count_q  <= {CntW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one pipelined device port among NrHosts hosts.
// Ports: clk_i/rst_i; host_req_i/host_gnt_o and flattened per-host payload
// (host i occupies slice i of host_addr_i/host_we_i/host_be_i/host_wdata_i);
// host_rvalid_o/host_rdata_o/host_err_o per-host response (rdata/err broadcast);
// dev_* shared device request and in-order response; unexpected_rvalid_o sticky
// flag for a response arriving with nothing outstanding.
module bus_host_arbiter
    import bus_host_arbiter_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]  host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              dev_req_o,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_gnt_i,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic                              unexpected_rvalid_o
);

    localparam int unsigned IdW  = $clog2(NrHosts);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                    lock_valid_q, lock_valid_d;
    logic [IdW-1:0]          lock_id_q, lock_id_d;
    logic                    unexpected_q, unexpected_d;
    logic [IdW-1:0]          sel, cand_id;
    logic                    any_req, grant, pop, spurious;
    logic                    fifo_full, fifo_empty;
    logic [CntW-1:0]         fifo_count;
    logic [IdW-1:0]          head_id;
    logic [AddressWidth-1:0] addr_arr  [NrHosts];
    logic [BeW-1:0]          be_arr    [NrHosts];
    logic [DataWidth-1:0]    wdata_arr [NrHosts];

    // Host selection: a locked, still-requesting host keeps the port; otherwise
    // the first requester at or after rr_ptr wins.
    always_comb begin
        sel     = rr_ptr_q;
        cand_id = rr_ptr_q;
        any_req = 1'b0;
        if (lock_valid_q && host_req_i[lock_id_q]) begin
            sel     = lock_id_q;
            any_req = 1'b1;
        end else begin
            for (int i = 0; i < int'(NrHosts); i++) begin
                cand_id = IdW'((32'(rr_ptr_q) + 32'(i)) % NrHosts);
                if (!any_req && host_req_i[cand_id]) begin
                    sel     = cand_id;
                    any_req = 1'b1;
                end else begin
                    sel = sel;
                end
            end
        end
    end

    // Device request, zero-latency payload mux, grants and response routing.
    always_comb begin
        for (int i = 0; i < int'(NrHosts); i++) begin
            addr_arr[i]  = host_addr_i[i*AddressWidth +: AddressWidth];
            be_arr[i]    = host_be_i[i*BeW +: BeW];
            wdata_arr[i] = host_wdata_i[i*DataWidth +: DataWidth];
        end
        // fullness looks only at the registered count, so a same-cycle pop
        // does not open a slot until the next cycle
        dev_req_o     = any_req && !fifo_full && !rst_i;
        dev_addr_o    = addr_arr[sel];
        dev_we_o      = host_we_i[sel];
        dev_be_o      = be_arr[sel];
        dev_wdata_o   = wdata_arr[sel];
        grant         = dev_req_o && dev_gnt_i;
        pop           = dev_rvalid_i && !fifo_empty && !rst_i;
        spurious      = dev_rvalid_i && (fifo_count == CntW'(0)) && !rst_i;
        host_gnt_o    = {NrHosts{1'b0}};
        host_rvalid_o = {NrHosts{1'b0}};
        for (int i = 0; i < int'(NrHosts); i++) begin
            host_gnt_o[i]    = grant && (sel == IdW'(i));
            host_rvalid_o[i] = pop && (head_id == IdW'(i));
        end
        host_rdata_o = {NrHosts{dev_rdata_i}};
        host_err_o   = {NrHosts{dev_err_i}};
    end

    // Next-state for rr pointer, lock and sticky spurious-response flag.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = 1'b0;
        lock_id_d    = lock_id_q;
        unexpected_d = unexpected_q || spurious;
        if (grant) begin
            rr_ptr_d = IdW'(wrap_inc(32'(sel), NrHosts));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        // an offered but unaccepted request pins the selection; if that host
        // drops its request the lock simply fails to re-arm
        if (dev_req_o && !dev_gnt_i) begin
            lock_valid_d = 1'b1;
            lock_id_d    = sel;
        end else begin
            lock_valid_d = 1'b0;
        end
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= {IdW{1'b0}};
            lock_valid_q <= 1'b0;
            lock_id_q    <= {IdW{1'b0}};
            unexpected_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            unexpected_q <= unexpected_d;
        end
    end

    assign unexpected_rvalid_o = unexpected_q;

    bus_host_arbiter_id_fifo #(
        .Depth   (MaxOutstanding),
        .IdWidth (IdW)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (grant),
        .push_id_i (sel),
        .pop_i     (pop),
        .head_id_o (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
module tb_bus_host_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [N*AW-1:0] host_addr;
    logic [N*4-1:0]  host_be;
    logic [N*DW-1:0] host_wdata, host_rdata;
    logic            dev_req, dev_we, dev_gnt, dev_rvalid, dev_err, unexp;
    logic [AW-1:0]   dev_addr;
    logic [3:0]      dev_be;
    logic [DW-1:0]   dev_wdata, dev_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    // reference model state (spec-level view)
    int   m_rr   = 0;
    int   m_lock = -1;
    int   m_q[$];
    bit   m_unexp = 1'b0;
    rsp_t exp_rq[$];

    always #5 clk = ~clk;

    bus_host_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt),
        .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
        .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
        .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
        .dev_err_i(dev_err), .unexpected_rvalid_o(unexp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one bus cycle: drive at posedge+1, check/advance model at negedge
    task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic er, input logic r);
        rsp_t        e;
        int          sel;
        bit          exp_req;
        logic [1:0]  exp_gnt;
        host_req   = req;
        dev_gnt    = gnt;
        dev_rvalid = rv;
        dev_rdata  = rd;
        dev_err    = er;
        rst        = r;
        host_addr  = {$urandom, $urandom};
        host_wdata = {$urandom, $urandom};
        host_we    = 2'($urandom);
        host_be    = 8'($urandom);
        if (!r && rv && m_q.size() > 0) begin
            e.host = m_q[0];
            e.data = rd;
            e.err  = er;
            exp_rq.push_back(e);
        end
        @(negedge clk);
        exp_req = !r && (req != 2'b00) && (m_q.size() < MO);
        if (m_lock >= 0 && req[m_lock]) begin
            sel = m_lock;
        end else begin
            sel = m_rr;
            for (int k = 0; k < N; k++) begin
                if (req[(m_rr + k) % N]) begin
                    sel = (m_rr + k) % N;
                    break;
                end
            end
        end
        exp_gnt = (exp_req && gnt) ? 2'(1 << sel) : 2'b00;
        chk("dev_req", 64'(dev_req), 64'(exp_req));
        chk("host_gnt", 64'(host_gnt), 64'(exp_gnt));
        chk("unexpected_rvalid", 64'(unexp), 64'(m_unexp));
        chk("host_rdata_bcast", host_rdata, {rd, rd});
        chk("host_err_bcast", 64'(host_err), 64'({er, er}));
        if (exp_req) begin
            chk("dev_addr", 64'(dev_addr), 64'(host_addr[sel*AW +: AW]));
            chk("dev_we", 64'(dev_we), 64'(host_we[sel]));
            chk("dev_be", 64'(dev_be), 64'(host_be[sel*4 +: 4]));
            chk("dev_wdata", 64'(dev_wdata), 64'(host_wdata[sel*DW +: DW]));
        end
        if (r) begin
            m_rr   = 0;
            m_lock = -1;
            m_q.delete();
            m_unexp = 1'b0;
        end else begin
            if (rv) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_unexp = 1'b1;
            end
            if (exp_req && gnt) begin
                m_q.push_back(sel);
                m_rr = (sel + 1) % N;
            end
            m_lock = (exp_req && !gnt) ? sel : -1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b0;
        dev_rdata = 32'h0; dev_err = 1'b0;
        host_addr = '0; host_wdata = '0; host_we = '0; host_be = '0;

        // response monitor: pops the scoreboard whenever a response is due or seen
        fork
            begin : monitor
                rsp_t me;
                forever begin
                    @(negedge clk);
                    if (host_rvalid != 2'b00) begin
                        if (exp_rq.size() == 0) begin
                            chk("rvalid_unexpected", 64'(host_rvalid), 64'd0);
                        end else begin
                            me = exp_rq.pop_front();
                            chk("rvalid_host", 64'(host_rvalid), 64'(1 << me.host));
                            chk("rsp_data", 64'(host_rdata[me.host*DW +: DW]), 64'(me.data));
                            chk("rsp_err", 64'(host_err[me.host]), 64'(me.err));
                        end
                    end else if (exp_rq.size() > 0) begin
                        me = exp_rq.pop_front();
                        chk("rvalid_missing", 64'(host_rvalid), 64'(1 << me.host));
                    end
                end
            end
        join_none

        @(posedge clk);
        #1;
        // reset holds outputs low, even with a response strobe present
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b11, 1'b1, 1'b1, 32'h1, 1'b0, 1'b1);
        // continuous requests, device always ready: alternating grants
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) cyc(2'b11, 1'b1, 1'b1, $urandom, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        // lock: host 0 stalled, host 1 joins, host 0 keeps the port
        cyc(2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        // routing: host 1 then host 0, in-order responses
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        // full: two grants outstanding blocks the third until after a response
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, $urandom, 1'b0, 1'b0);
        // error response for host 1
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        // spurious response is sticky until a one-cycle reset
        cyc(2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        // randomized traffic including stalls, dropped requests and resets
        for (int n = 0; n < 600; n++) begin
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), $urandom, 1'($urandom),
                ($urandom_range(0, 60) == 0));
        end
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rsp_queue_drained", 64'(exp_rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
